// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per clock, LSB first.
// Computes diff = (a - b - bin) mod 2^WIDTH and bout = (a < b + bin).
// A three-state FSM (IDLE -> RUN for WIDTH cycles -> DONE for one cycle)
// drives registered busy/done outputs. The result registers only update on
// DONE entry, so partial sums never appear on diff/bout.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Counter just wide enough to index every bit position.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_diff_sh;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_diff_next;

  // Full-subtractor on the current LSBs of the operand shift registers.
  assign w_x         = r_a_sh[0];
  assign w_y         = r_b_sh[0];
  assign w_d         = w_x ^ w_y ^ r_borrow;
  assign w_br_next   = (~w_x & w_y) | (~w_x & r_borrow) | (w_y & r_borrow);
  assign w_last_bit  = (r_cnt == CW'(WIDTH - 1));
  // The new bit enters at the top; after WIDTH shifts bit 0 is at position 0.
  assign w_diff_next = {w_d, r_diff_sh};

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

  // FSM with operand capture, serial datapath and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_diff_sh <= '0;
      r_borrow  <= 1'b0;
      r_cnt     <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_borrow  <= bin;
            r_diff_sh <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end else begin
            r_busy <= 1'b0;
          end
        end
        RUN: begin
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_borrow  <= w_br_next;
          r_diff_sh <= w_diff_next[WIDTH-1:1];
          r_cnt     <= r_cnt + 1'b1;
          r_busy    <= 1'b1;
          if (w_last_bit) begin
            r_diff  <= w_diff_next;
            r_bout  <= w_br_next;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a new subtraction; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  minuend, unsigned.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, unsigned.
REQ-007 SHALL have port: bin  input  1  borrow-in.
REQ-008 SHALL have port: busy  output  1  high while an operation is in RUN or DONE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; diff/bout valid and new.
REQ-010 SHALL have port: diff  output  WIDTH  registered result, (a - b - bin) mod 2^WIDTH.
REQ-011 SHALL have port: bout  output  1  registered borrow-out, 1 iff a < b + bin (unsigned).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: on an edge with start=1, SHALL capture a, b, bin into internal shift registers, clear the bit counter, and enter RUN; start=0 stays in IDLE.
REQ-014 RUN: each cycle SHALL process exactly one bit, LSB first, via full-subtractor: d = x^y^br; br_next = (~x&y) | (~x&br) | (y&br); the borrow register initialises to the captured bin.
REQ-015 RUN SHALL last exactly WIDTH cycles; after the WIDTH-th bit, it SHALL enter DONE.
REQ-016 On entry to DONE, diff and bout SHALL load the complete result in the same edge; partial results SHALL never appear on diff/bout.
REQ-017 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-018 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH.
REQ-019 busy SHALL be 1 exactly in RUN and DONE and 0 in IDLE (Moore output).
REQ-020 start, a, b and bin changes while busy SHALL be ignored and SHALL NOT affect the result in progress.
REQ-021 Back-to-back: start held high SHALL begin a new operation at the first IDLE edge; issue period = WIDTH+2 cycles.
REQ-022 diff/bout SHALL hold their last value in IDLE and RUN until the next DONE entry.
REQ-023 All arithmetic SHALL be unsigned modulo 2^WIDTH; no overflow flag beyond bout.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, diff=0, bout=0, and clear the shift registers, the counter and the borrow register.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as from power-up.

Verification (WIDTH=4)
REQ-026 Drive a=9, b=3, bin=0, one-cycle start at edge k -> busy high after edge k; done only in the cycle after edge k+4; diff=6, bout=0.
REQ-027 Drive a=3, b=9, bin=0 -> diff=10 (4'b1010), bout=1. Drive a=0, b=0, bin=1 -> diff=15, bout=1.
REQ-028 Drive a=15, b=15, bin=0 -> diff=0, bout=0. Drive a=15, b=0, bin=1 -> diff=14, bout=0.
REQ-029 Start a=9, b=3, then change to a=1, b=7 and pulse start during RUN -> result still diff=6, bout=0; no second operation starts.
REQ-030 Hold start=1 continuously -> a done pulse every 6 cycles; each result matches the operands sampled at its IDLE start edge.
REQ-031 Assert rst_n=0 asynchronously mid-RUN -> busy, done, diff and bout go 0 without a clock edge; no done follows; the next start produces a correct result.
